instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Fetch sequencer feeding the instruction decoder. It holds the program counter and issues reads to instruction RAM.
- It captures the returned 16-bit word into an instruction register and presents it to the decoder with a valid/accept handshake.
- It consumes the decoder's en_pc (advance/accept) and pc_mux_en (absolute jump) controls, plus a PC-relative displacement path, to compute the next PC.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- MEM_LAT, 1, instruction RAM read latency in cycles; legal range 1..4.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous active-low reset: reset=0 sampled at a rising edge resets the block.
- mem_addr  output  16  RAM read address; always equals the PC register.
- mem_rd_en  output  1  RAM read strobe; high only in the ISSUE state.
- mem_rdata  input  16  RAM read data; valid in the MEM_LAT-th cycle after the edge that samples mem_rd_en=1.
- instr  output  16  instruction register contents, presented to the decoder.
- instr_valid  output  1  high in the HOLD state.
- pc_out  output  16  address of the instruction currently in instr.
- en_pc  input  1  decoder accepts instr and advances the PC; ignored unless instr_valid=1.
- pc_mux_en  input  1  with en_pc, select the absolute target.
- jump_target  input  16  absolute next PC.
- rel_en  input  1  with en_pc, select PC-relative next PC.
- disp  input  8  signed displacement for the relative path.
- halt  input  1  stop issuing new fetches.
- halted  output  1  high in the IDLE state.
- instr_count  output  16  count of accepted instructions.

Behaviour:
- States are IDLE, ISSUE, WAIT and HOLD. The FSM is Moore; outputs decode from state and registers only.
- Reset (reset=0 at an edge), regardless of state:
  - pc=RESET_PC, ir=16'h0000, instr_count=0, wait counter=0, state=ISSUE.
  - Outputs after reset: mem_rd_en=1 (ISSUE), instr_valid=0, halted=0, instr=0, pc_out=RESET_PC.
  - Any read in flight when reset hits is abandoned; its returning data is never captured.
- ISSUE, one cycle:
  - mem_rd_en=1, mem_addr=pc.
  - Next state is WAIT, with the wait counter loaded to MEM_LAT.
  - halt has no effect once ISSUE has been entered.
- WAIT:
  - mem_rd_en=0; the counter decrements each cycle.
  - In the cycle where counter==1, ir<=mem_rdata at the closing edge and the state goes to HOLD.
  - WAIT lasts exactly MEM_LAT cycles.
- HOLD:
  - instr_valid=1; instr and pc_out stay stable until accepted.
  - When en_pc=1 at an edge, the accept happens:
    - pc<=pc_next;
    - instr_count<=instr_count+1, wrapping FFFF->0000;
    - next state is IDLE if halt=1, else ISSUE.
  - While en_pc=0, the FSM stays in HOLD indefinitely.
- pc_next priority:
  - pc_mux_en=1 gives jump_target.
  - else rel_en=1 gives pc + sign_extend16(disp).
  - else pc + 1.
  - All arithmetic is modulo 2^16: FFFF+1=0000, and 0002+disp(8'hFC)=FFFE.
- IDLE:
  - halted=1, mem_rd_en=0, instr_valid=0.
  - Moves to ISSUE on the first cycle halt=0 is sampled.
- Fetch latency: from the ISSUE cycle to the first instr_valid cycle is MEM_LAT+1 cycles. Throughput is one instruction per MEM_LAT+2 cycles when the decoder accepts immediately.
- en_pc, pc_mux_en and rel_en sampled outside HOLD are ignored: PC and count are unchanged.
- pc_mux_en and rel_en without en_pc have no effect.

Test Plan:
- Reset with RESET_PC=0010, MEM_LAT=1 -> mem_rd_en=1 and mem_addr=0010 in the first cycle after reset. With RAM[0010]=1234, instr_valid rises 2 cycles later with instr=1234 and pc_out=0010.
- Sequential fetch: hold en_pc=1 continuously -> mem_addr sequence 0010, 0011, 0012, with one accept every 3 cycles; after 3 accepts instr_count=3.
- Jump and relative:
  - accept at pc 0020 with pc_mux_en=1, jump_target=0400 -> next mem_addr=0400;
  - accept at 0002 with rel_en=1, disp=FC -> next mem_addr=FFFE;
  - accept at 0010 with both pc_mux_en=1 (jump_target=0400) and rel_en=1 -> next mem_addr=0400, because absolute wins;
  - accept at FFFF with neither control -> next mem_addr=0000.
- Stall and halt:
  - en_pc held 0 for 10 cycles -> instr and pc_out stay stable;
  - then accept with halt=1 -> halted=1 and no mem_rd_en while halt stays 1;
  - release halt -> ISSUE on the next cycle at the updated PC.
- MEM_LAT=3 -> instr_valid 4 cycles after ISSUE; en_pc pulsed during WAIT is ignored (PC and count unchanged).
- Reset asserted in WAIT -> state returns to ISSUE at RESET_PC, instr_count=0, and the stale mem_rdata is not captured.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// instr_fetch_unit_if : RAM-read and decoder-handshake bundle of the fetch unit
// Rev 1.0
// ---------------------------------------------------------------------------
interface instr_fetch_unit_if;
  logic [15:0] mem_addr;
  logic        mem_rd_en;
  logic [15:0] mem_rdata;
  logic [15:0] instr;
  logic        instr_valid;
  logic [15:0] pc_out;
  logic        en_pc;
  logic        pc_mux_en;
  logic [15:0] jump_target;
  logic        rel_en;
  logic [7:0]  disp;
  logic        halt;
  logic        halted;
  logic [15:0] instr_count;

  // master: the fetch unit itself; slave: the RAM plus decoder side
  modport master (
    output mem_addr, mem_rd_en, instr, instr_valid, pc_out, halted, instr_count,
    input  mem_rdata, en_pc, pc_mux_en, jump_target, rel_en, disp, halt
  );

  modport slave (
    input  mem_addr, mem_rd_en, instr, instr_valid, pc_out, halted, instr_count,
    output mem_rdata, en_pc, pc_mux_en, jump_target, rel_en, disp, halt
  );
endinterface
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// instr_fetch_unit : PC sequencer, instruction-RAM reader and IR for the decoder
// Rev 1.0
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          MEM_LAT  = 1          // legal range 1..4
) (
  input  logic                      clk,
  input  logic                      reset,
  instr_fetch_unit_if.master        bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  localparam logic [2:0] LAT_LOAD = 3'(MEM_LAT);

  logic [1:0]  state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] count_q, count_d;
  logic [2:0]  wait_q, wait_d;

  logic [15:0] disp_ext;
  logic [15:0] pc_next;

  // Absolute jump outranks the relative path, which outranks sequential.
  always_comb begin
    disp_ext = {{8{bus.disp[7]}}, bus.disp};
    if (bus.pc_mux_en) begin
      pc_next = bus.jump_target;
    end else if (bus.rel_en) begin
      pc_next = pc_q + disp_ext;
    end else begin
      pc_next = pc_q + 16'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    count_d = count_q;
    wait_d  = wait_q;
    case (state_q)
      S_ISSUE: begin
        state_d = S_WAIT;
        wait_d  = LAT_LOAD;
      end
      S_WAIT: begin
        wait_d = wait_q - 3'd1;
        if (wait_q == 3'd1) begin
          ir_d    = bus.mem_rdata;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (bus.en_pc) begin
          pc_d    = pc_next;
          count_d = count_q + 16'd1;
          state_d = bus.halt ? S_IDLE : S_ISSUE;
        end
      end
      default: begin
        if (!bus.halt) begin
          state_d = S_ISSUE;
        end
      end
    endcase
  end

  // Reset lands in ISSUE, so any read still in flight is simply never captured.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_ISSUE;
      pc_q    <= RESET_PC;
      ir_q    <= 16'h0000;
      count_q <= 16'h0000;
      wait_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      count_q <= count_d;
      wait_q  <= wait_d;
    end
  end

  assign bus.mem_addr    = pc_q;
  assign bus.mem_rd_en   = (state_q == S_ISSUE);
  assign bus.instr       = ir_q;
  assign bus.instr_valid = (state_q == S_HOLD);
  assign bus.pc_out      = pc_q;
  assign bus.halted      = (state_q == S_IDLE);
  assign bus.instr_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit : bench for instr_fetch_unit (MEM_LAT=1 and MEM_LAT=3)
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;

  localparam logic [15:0] POISON = 16'hDEAD;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset1;
  logic reset3;

  instr_fetch_unit_if if1 ();
  instr_fetch_unit_if if3 ();

  instr_fetch_unit #(.RESET_PC(16'h0010), .MEM_LAT(1)) dut1 (
    .clk(clk), .reset(reset1), .bus(if1)
  );
  instr_fetch_unit #(.RESET_PC(16'h0200), .MEM_LAT(3)) dut3 (
    .clk(clk), .reset(reset3), .bus(if3)
  );

  function automatic logic [15:0] ram_word(input logic [15:0] a);
    if (a == 16'h0010) return 16'h1234;
    return {a[7:0], a[15:8]} ^ 16'h5A5A;
  endfunction

  // Pipelined RAM models: data shows up only in the MEM_LAT-th cycle after the read.
  logic [15:0] pipe1;
  logic [15:0] pipe3 [0:2];
  always @(posedge clk) begin
    pipe1    <= if1.mem_rd_en ? ram_word(if1.mem_addr) : POISON;
    pipe3[0] <= if3.mem_rd_en ? ram_word(if3.mem_addr) : POISON;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign if1.mem_rdata = pipe1;
  assign if3.mem_rdata = pipe3[2];

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] word;
  } fetch_t;

  typedef struct {
    logic [15:0] start;
    logic        pmux;
    logic        rel;
    logic [15:0] tgt;
    logic [7:0]  disp;
    logic [15:0] exp_next;
  } vec_t;

  fetch_t exp_q [$];
  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  task automatic fail(input string name);
    checks++;
    $display("FAIL %s: got no event, required one", name);
  endtask

  // Scoreboard monitor for dut1: fetch addresses and each newly presented instruction.
  logic   prev_valid1 = 1'b0;
  fetch_t mon_e;
  always @(negedge clk) begin
    if (if1.mem_rd_en) begin
      if (exp_q.size() == 0) fail("unexpected_fetch");
      else check("fetch_addr", if1.mem_addr, exp_q[0].pc);
    end
    if (if1.instr_valid && !prev_valid1) begin
      if (exp_q.size() == 0) fail("unexpected_instr");
      else begin
        mon_e = exp_q.pop_front();
        check("sb_pc_out", if1.pc_out, mon_e.pc);
        check("sb_instr", if1.instr, mon_e.word);
      end
    end
    prev_valid1 <= if1.instr_valid;
  end

  task automatic wait_valid(input int which, output int cyc);
    cyc = 0;
    while (((which == 1) ? !if1.instr_valid : !if3.instr_valid) && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
    if ((which == 1) ? !if1.instr_valid : !if3.instr_valid) fail("timeout_valid");
  endtask

  task automatic accept1(input logic pmux, input logic rel, input logic [15:0] tgt,
                         input logic [7:0] d, input logic h, input logic [15:0] exp_next);
    int c;
    wait_valid(1, c);
    if1.en_pc       = 1'b1;
    if1.pc_mux_en   = pmux;
    if1.rel_en      = rel;
    if1.jump_target = tgt;
    if1.disp        = d;
    if1.halt        = h;
    exp_q.push_back(fetch_t'({exp_next, ram_word(exp_next)}));
    @(negedge clk);
    if1.en_pc     = 1'b0;
    if1.pc_mux_en = 1'b0;
    if1.rel_en    = 1'b0;
  endtask

  vec_t vecs [6];

  initial begin
    int c;
    int lat;
    logic ok;
    logic [15:0] saved_i;
    logic [15:0] saved_p;

    vecs[0] = '{16'h0020, 1'b1, 1'b0, 16'h0400, 8'h00, 16'h0400};
    vecs[1] = '{16'h0002, 1'b0, 1'b1, 16'h0000, 8'hFC, 16'hFFFE};
    vecs[2] = '{16'h0010, 1'b1, 1'b1, 16'h0400, 8'h05, 16'h0400};
    vecs[3] = '{16'hFFFF, 1'b0, 1'b0, 16'h0000, 8'h00, 16'h0000};
    vecs[4] = '{16'h0080, 1'b0, 1'b1, 16'h0000, 8'h7F, 16'h00FF};
    vecs[5] = '{16'h0100, 1'b0, 1'b1, 16'h0000, 8'h80, 16'h0080};

    reset1 = 1'b0;
    reset3 = 1'b0;
    if1.en_pc = 1'b0; if1.pc_mux_en = 1'b0; if1.rel_en = 1'b0;
    if1.jump_target = 16'h0; if1.disp = 8'h0; if1.halt = 1'b0;
    if3.en_pc = 1'b0; if3.pc_mux_en = 1'b0; if3.rel_en = 1'b0;
    if3.jump_target = 16'h0; if3.disp = 8'h0; if3.halt = 1'b0;
    exp_q.push_back(fetch_t'({16'h0010, 16'h1234}));

    repeat (3) @(negedge clk);
    check("rst_rd_en", 16'(if1.mem_rd_en), 16'd1);
    check("rst_addr", if1.mem_addr, 16'h0010);
    check("rst_valid", 16'(if1.instr_valid), 16'd0);
    check("rst_halted", 16'(if1.halted), 16'd0);
    check("rst_instr", if1.instr, 16'h0000);
    check("rst_pc_out", if1.pc_out, 16'h0010);
    check("rst_count", if1.instr_count, 16'h0000);

    reset1 = 1'b1;
    wait_valid(1, lat);
    check("latency_lat1", 16'(lat), 16'd2);

    // Continuous accept: one instruction every MEM_LAT+2 = 3 cycles.
    if1.en_pc = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_valid(1, c);
      if (i > 0) check("accept_period", 16'(c + 1), 16'd3);
      exp_q.push_back(fetch_t'({16'h0011 + 16'(i), ram_word(16'h0011 + 16'(i))}));
      @(negedge clk);
    end
    if1.en_pc = 1'b0;
    check("count_after_seq", if1.instr_count, 16'd3);

    for (int v = 0; v < 6; v++) begin
      accept1(1'b1, 1'b0, vecs[v].start, 8'h00, 1'b0, vecs[v].start);
      accept1(vecs[v].pmux, vecs[v].rel, vecs[v].tgt, vecs[v].disp, 1'b0, vecs[v].exp_next);
      check("vec_rd_en", 16'(if1.mem_rd_en), 16'd1);
      check("vec_next_addr", if1.mem_addr, vecs[v].exp_next);
    end
    check("count_after_vecs", if1.instr_count, 16'd15);

    // Stall ten cycles, then accept into IDLE and release.
    wait_valid(1, c);
    saved_i = if1.instr;
    saved_p = if1.pc_out;
    ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (!if1.instr_valid || if1.instr !== saved_i || if1.pc_out !== saved_p) ok = 1'b0;
    end
    check("stall_stable", 16'(ok), 16'd1);
    check("stall_pc_out", saved_p, 16'h0080);

    accept1(1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 16'h0081);
    ok = 1'b1;
    repeat (5) begin
      if (!if1.halted || if1.mem_rd_en || if1.instr_valid) ok = 1'b0;
      @(negedge clk);
    end
    check("halt_idle", 16'(ok), 16'd1);
    check("count_after_halt", if1.instr_count, 16'd16);
    if1.halt = 1'b0;
    @(negedge clk);
    check("resume_rd_en", 16'(if1.mem_rd_en), 16'd1);
    check("resume_addr", if1.mem_addr, 16'h0081);
    wait_valid(1, c);

    // MEM_LAT=3 instance.
    check("l3_rst_rd_en", 16'(if3.mem_rd_en), 16'd1);
    check("l3_rst_addr", if3.mem_addr, 16'h0200);
    reset3 = 1'b1;
    wait_valid(3, lat);
    check("latency_lat3", 16'(lat), 16'd4);
    check("l3_instr", if3.instr, ram_word(16'h0200));
    check("l3_pc_out", if3.pc_out, 16'h0200);

    if3.en_pc = 1'b1;
    @(negedge clk);
    if3.en_pc = 1'b0;
    check("l3_issue_addr", if3.mem_addr, 16'h0201);
    @(negedge clk);
    if3.en_pc = 1'b1; if3.pc_mux_en = 1'b1; if3.jump_target = 16'h1234;
    @(negedge clk);
    if3.en_pc = 1'b0; if3.pc_mux_en = 1'b0;
    wait_valid(3, c);
    check("l3_latency_2", 16'(c + 2), 16'd4);
    check("wait_en_pc_ignored", if3.pc_out, 16'h0201);
    check("wait_count_unchanged", if3.instr_count, 16'd1);
    check("l3_instr_2", if3.instr, ram_word(16'h0201));

    // Reset while a read for 0202 is in flight.
    if3.en_pc = 1'b1;
    @(negedge clk);
    if3.en_pc = 1'b0;
    @(negedge clk);
    reset3 = 1'b0;
    @(negedge clk);
    reset3 = 1'b1;
    check("wrst_count", if3.instr_count, 16'd0);
    check("wrst_instr", if3.instr, 16'h0000);
    check("wrst_pc_out", if3.pc_out, 16'h0200);
    check("wrst_rd_en", 16'(if3.mem_rd_en), 16'd1);
    check("wrst_valid", 16'(if3.instr_valid), 16'd0);
    wait_valid(3, lat);
    check("wrst_latency", 16'(lat), 16'd4);
    check("stale_not_captured", if3.instr, ram_word(16'h0200));
    check("wrst_pc_after", if3.pc_out, 16'h0200);

    check("scoreboard_drained", 16'(exp_q.size()), 16'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
